// File: rtl/wbdownsz.sv
// wbdownsz: splits one wide Wishbone request into a sequence of narrow-bus beats
// and reassembles the returned lanes into a single wide acknowledgement.
module wbdownsz #(
  parameter int ADDRESS_WIDTH     = 28,
  parameter int WIDE_DW           = 512,
  parameter int SMALL_DW          = 32,
  parameter bit OPT_LITTLE_ENDIAN = 1'b0,
  parameter bit OPT_LOWPOWER      = 1'b0
) (
  input  logic                                            i_clk,
  input  logic                                            i_reset,
  input  logic                                            i_wcyc,
  input  logic                                            i_wstb,
  input  logic                                            i_wwe,
  input  logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]      i_waddr,
  input  logic [WIDE_DW-1:0]                              i_wdata,
  input  logic [WIDE_DW/8-1:0]                            i_wsel,
  output logic                                            o_wstall,
  output logic                                            o_wack,
  output logic                                            o_werr,
  output logic [WIDE_DW-1:0]                              o_wdata,
  output logic                                            o_scyc,
  output logic                                            o_sstb,
  output logic                                            o_swe,
  output logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0]     o_saddr,
  output logic [SMALL_DW-1:0]                             o_sdata,
  output logic [SMALL_DW/8-1:0]                           o_ssel,
  input  logic                                            i_sstall,
  input  logic                                            i_sack,
  input  logic                                            i_serr,
  input  logic [SMALL_DW-1:0]                             i_sdata
);
  localparam int R   = WIDE_DW / SMALL_DW;
  localparam int LGR = (R > 1) ? $clog2(R) : 1;
  localparam int CW  = LGR + 1;
  localparam int SB  = SMALL_DW / 8;
  localparam int WAW = ADDRESS_WIDTH - $clog2(WIDE_DW/8);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  function automatic logic [LGR-1:0] lowest(input logic [R-1:0] m);
    lowest = '0;
    for (int i = R-1; i >= 0; i--) if (m[i]) lowest = LGR'(i);
  endfunction
  // Lane index to bit-slice position, honouring the lane ordering option
  function automatic int pos(input logic [LGR-1:0] k);
    return OPT_LITTLE_ENDIAN ? int'(k) : R-1-int'(k);
  endfunction
  if (R == 1) begin : g_pass
    assign o_scyc   = i_wcyc;
    assign o_sstb   = i_wstb;
    assign o_swe    = i_wwe;
    assign o_saddr  = i_waddr;
    assign o_sdata  = i_wdata;
    assign o_ssel   = i_wsel;
    assign o_wstall = i_sstall;
    assign o_wack   = i_sack;
    assign o_werr   = i_serr;
    assign o_wdata  = i_sdata;
  end else begin : g_split
    state_t state, state_n;
    logic r_we, wack, werr;
    logic [WAW-1:0] r_addr;
    logic [WIDE_DW-1:0] r_data, r_ret;
    logic [WIDE_DW/8-1:0] r_sel;
    logic [R-1:0] iss_m, ack_m, sel_m, iss_left, ack_left;
    logic [LGR-1:0] iss_k, ack_k;
    logic [CW-1:0] count;
    logic accept, issue, ack, err, abort, done;
    always_comb begin
      sel_m = '0;
      for (int k = 0; k < R; k++) sel_m[k] = |i_wsel[pos(LGR'(k))*SB +: SB];
      iss_k    = lowest(iss_m);
      ack_k    = lowest(ack_m);
      iss_left = iss_m & ~(R'(1) << iss_k);
      ack_left = ack_m & ~(R'(1) << ack_k);
      accept   = state == IDLE && i_wcyc && i_wstb;
      issue    = state == ISSUE && !i_sstall;
      ack      = state != IDLE && i_sack && count != '0;
      err      = state != IDLE && i_serr;
      abort    = state != IDLE && !i_wcyc;
      done     = ack && ack_left == '0;
      state_n  = accept ? ((|sel_m) ? ISSUE : IDLE)
               : (abort || err || done) ? IDLE
               : (issue && iss_left == '0) ? DRAIN : state;
    end
    always_ff @(posedge i_clk) state <= i_reset ? IDLE : state_n;
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_we   <= 1'b0;
        r_addr <= '0;
        r_data <= '0;
        r_sel  <= '0;
        r_ret  <= '0;
        iss_m  <= '0;
        ack_m  <= '0;
        count  <= '0;
        wack   <= 1'b0;
        werr   <= 1'b0;
      end else begin
        wack <= (done && !err && !abort) || (accept && sel_m == '0);
        werr <= err && !abort;
        if (accept) begin
          r_we   <= i_wwe;
          r_addr <= i_waddr;
          r_data <= i_wdata;
          r_sel  <= i_wsel;
          r_ret  <= '0;
          iss_m  <= sel_m;
          ack_m  <= sel_m;
          count  <= '0;
        end else if (abort || err) begin
          iss_m <= '0;
          ack_m <= '0;
          count <= '0;
        end else begin
          if (issue) iss_m <= iss_left;
          if (ack) begin
            ack_m <= ack_left;
            r_ret[pos(ack_k)*SMALL_DW +: SMALL_DW] <= i_sdata;
          end
          count <= count + CW'(issue) - CW'(ack);
        end
      end
    end
    assign o_scyc   = state != IDLE;
    assign o_sstb   = state == ISSUE;
    assign o_wstall = state != IDLE;
    assign o_swe    = r_we;
    assign o_saddr  = (OPT_LOWPOWER && !o_sstb) ? '0 : {r_addr, iss_k};
    assign o_sdata  = (OPT_LOWPOWER && !o_sstb) ? '0 : r_data[pos(iss_k)*SMALL_DW +: SMALL_DW];
    assign o_ssel   = (OPT_LOWPOWER && !o_sstb) ? '0 : r_sel[pos(iss_k)*SB +: SB];
    assign o_wack   = wack;
    assign o_werr   = werr;
    assign o_wdata  = (OPT_LOWPOWER && !wack) ? '0 : r_ret;
  end
endmodule

// File: tb/tb_wbdownsz.sv
// tb_wbdownsz: directed and random requests on a 128->32 little-endian downsizer,
// with a narrow-bus responder and a lane-list reference model.
module tb_wbdownsz;
  logic i_clk = 1'b0, i_reset = 1'b1;
  logic i_wcyc = 0, i_wstb = 0, i_wwe = 0;
  logic [23:0] i_waddr = '0;
  logic [127:0] i_wdata = '0;
  logic [15:0] i_wsel = '0;
  logic o_wstall, o_wack, o_werr;
  logic [127:0] o_wdata;
  logic o_scyc, o_sstb, o_swe;
  logic [25:0] o_saddr;
  logic [31:0] o_sdata;
  logic [3:0] o_ssel;
  logic i_sstall = 0, i_sack = 0, i_serr = 0;
  logic [31:0] i_sdata = '0;
  int tests = 0, fails = 0;
  logic [31:0] force_sd = '0;
  logic [127:0] last_wdata;

  wbdownsz #(.ADDRESS_WIDTH(28), .WIDE_DW(128), .SMALL_DW(32),
             .OPT_LITTLE_ENDIAN(1'b1), .OPT_LOWPOWER(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wcyc(i_wcyc), .i_wstb(i_wstb), .i_wwe(i_wwe), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_wsel(i_wsel),
    .o_wstall(o_wstall), .o_wack(o_wack), .o_werr(o_werr), .o_wdata(o_wdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe), .o_saddr(o_saddr),
    .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sstall(i_sstall), .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata));

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit we, input logic [23:0] addr, input logic [127:0] data,
                        input logic [15:0] sel, input int stall_lane, input int stall_n,
                        input int err_at);
    int lanes[$];
    logic [25:0] cap_a[$];
    logic [31:0] cap_d[$];
    logic [3:0] cap_s[$];
    bit cap_w[$];
    logic [127:0] exp_rd = '0;
    logic [31:0] d;
    int issued = 0, acked = 0, stalls = 0, inflight = 0, cyc = 0;
    bit got_ack = 0, got_err = 0, saw_scyc = 0, exp_err;
    for (int k = 0; k < 4; k++) if (sel[k*4 +: 4] != 4'h0) lanes.push_back(k);
    exp_err = err_at > 0 && err_at <= lanes.size();
    @(negedge i_clk);
    chk("idle_stall", o_wstall, 0);
    i_wcyc = 1; i_wstb = 1; i_wwe = we; i_waddr = addr; i_wdata = data; i_wsel = sel;
    @(negedge i_clk);
    i_wstb = 0;
    while (!got_ack && !got_err && cyc < 60) begin
      got_ack = o_wack;
      got_err = o_werr;
      if (o_scyc) saw_scyc = 1;
      if (!(got_ack || got_err)) begin
        i_sack = 0; i_serr = 0; i_sstall = 0;
        if (inflight > 0 && $urandom_range(0, 2) != 0) begin
          inflight--; acked++;
          if (acked == err_at) i_serr = 1;
          else begin
            d = (force_sd != 0) ? force_sd : $urandom;
            i_sack = 1; i_sdata = d;
            if (acked <= lanes.size()) exp_rd[lanes[acked-1]*32 +: 32] = d;
          end
        end
        if (o_sstb) begin
          if (issued == stall_lane && stalls < stall_n) begin
            i_sstall = 1; stalls++;
            chk("stall_addr", o_saddr, {addr, 2'(lanes[issued])});
          end else begin
            cap_a.push_back(o_saddr); cap_d.push_back(o_sdata);
            cap_s.push_back(o_ssel); cap_w.push_back(o_swe);
            issued++; inflight++;
          end
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    last_wdata = o_wdata;
    i_sack = 0; i_serr = 0; i_sstall = 0; i_wcyc = 0;
    chk("resp_ack", got_ack, !exp_err);
    chk("resp_err", got_err, exp_err);
    chk("resp_both", o_wack & o_werr, 0);
    chk("scyc_drop", o_scyc, 0);
    chk("saw_scyc", saw_scyc, lanes.size() != 0);
    if (lanes.size() == 0) chk("zero_lat", cyc, 0);
    if (got_ack) chk("rdata", o_wdata, exp_rd);
    if (!exp_err) chk("n_beats", cap_a.size(), lanes.size());
    else chk("err_beats_le", cap_a.size() <= lanes.size(), 1);
    for (int i = 0; i < cap_a.size() && i < lanes.size(); i++) begin
      chk("beat_addr", cap_a[i], {addr, 2'(lanes[i])});
      chk("beat_data", cap_d[i], data[lanes[i]*32 +: 32]);
      chk("beat_sel", cap_s[i], sel[lanes[i]*4 +: 4]);
      chk("beat_we", cap_w[i], we);
    end
    @(negedge i_clk);
    chk("one_pulse", {o_wack, o_werr}, 0);
  endtask

  task automatic start_and_drain;
    int n = 0;
    @(negedge i_clk);
    i_wcyc = 1; i_wstb = 1; i_wwe = 0; i_waddr = 24'h55; i_wsel = 16'hFFFF;
    @(negedge i_clk);
    i_wstb = 0;
    while (o_sstb && n < 20) begin @(negedge i_clk); n++; end
    chk("drain_reached", {o_scyc, o_sstb}, 2'b10);
  endtask

  task automatic late_acks;
    for (int i = 0; i < 3; i++) begin
      i_sack = 1; i_sdata = $urandom;
      @(negedge i_clk);
      chk("late_ack_quiet", {o_wack, o_werr, o_scyc}, 0);
    end
    i_sack = 0;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 0;
    chk("rst_ctl", {o_scyc, o_sstb, o_wack, o_werr, o_wstall, o_swe}, 0);
    chk("rst_saddr", o_saddr, 0);
    chk("rst_sdata", {o_sdata, o_ssel}, 0);
    chk("rst_wdata", o_wdata, 0);
    do_req(1, 24'h10, {32'h44, 32'h33, 32'h22, 32'h11}, 16'hFFFF, -1, 0, 0);
    force_sd = 32'hDEADBEEF;
    do_req(0, 24'h20, '0, 16'h0F00, -1, 0, 0);
    chk("lane2_read", last_wdata, 128'h00000000_DEADBEEF_00000000_00000000);
    force_sd = '0;
    do_req(0, 24'h30, '0, 16'h0000, -1, 0, 0);
    chk("zero_sel_data", last_wdata, 0);
    do_req(0, 24'h40, '0, 16'hFFFF, 1, 3, 0);
    do_req(1, 24'h50, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, -1, 0, 2);
    do_req(1, 24'h60, {$urandom, $urandom, $urandom, $urandom}, 16'hF0F1, -1, 0, 0);
    start_and_drain();
    i_wcyc = 0;
    @(negedge i_clk);
    chk("abort_scyc", {o_scyc, o_wack, o_werr}, 0);
    late_acks();
    start_and_drain();
    i_reset = 1;
    @(negedge i_clk);
    i_reset = 0; i_wcyc = 0;
    chk("rst_mid_scyc", {o_scyc, o_sstb, o_wack, o_werr, o_wstall}, 0);
    chk("rst_mid_wdata", o_wdata, 0);
    late_acks();
    do_req(0, 24'h70, '0, 16'h00F0, -1, 0, 0);
    for (int r = 0; r < 20; r++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      do_req(1'($urandom), 24'($urandom), {$urandom, $urandom, $urandom, $urandom}, s,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wbdownsz.md
WBDOWNSZ -- requirements
Module: wbdownsz

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 28, byte address width.
REQ-002 SHALL have parameter WIDE_DW, default 512, incoming (slave-side) data width.
REQ-003 SHALL have parameter SMALL_DW, default 32, outgoing (master-side) data width.
REQ-004 SHALL have parameter OPT_LITTLE_ENDIAN, default 1'b0, lane ordering.
REQ-005 SHALL have parameter OPT_LOWPOWER, default 1'b0, zeroes idle data and select outputs.
REQ-006 SHALL have ports:
 i_clk  in  1  sole clock
 i_reset  in  1  synchronous, active-high reset
 i_wcyc, i_wstb, i_wwe  in  1 each  wide request
 i_waddr  in  ADDRESS_WIDTH-$clog2(WIDE_DW/8)  wide word address
 i_wdata  in  WIDE_DW  write data
 i_wsel  in  WIDE_DW/8  byte selects
 o_wstall, o_wack, o_werr  out  1 each  wide response
 o_wdata  out  WIDE_DW  read data
 o_scyc, o_sstb, o_swe  out  1 each  small request
 o_saddr  out  ADDRESS_WIDTH-$clog2(SMALL_DW/8)  small word address
 o_sdata  out  SMALL_DW  write data
 o_ssel  out  SMALL_DW/8  byte selects
 i_sstall, i_sack, i_serr  in  1 each  small response
 i_sdata  in  SMALL_DW  read data

Function
REQ-007 WIDE_DW==SMALL_DW SHALL pass all signals straight through, with no registers.
REQ-008 Otherwise R=WIDE_DW/SMALL_DW; wide word splits into R lanes; lane k = bits [k*SMALL_DW +: SMALL_DW] if little-endian, else the k-th lane counted from the MSB.
REQ-009 Lane k SHALL map to o_saddr = {latched wide address, k[log2 R-1:0]}.
REQ-010 States: IDLE, ISSUE, DRAIN, with one wide request in flight at a time.
REQ-011 IDLE: o_wstall=0; accept on i_wcyc&&i_wstb; latch we, address, data, sel; pending mask = lanes with nonzero sel slice.
REQ-012 Accept with all sel zero SHALL skip the small bus and assert o_wack the next cycle with o_wdata=0, then return to IDLE.
REQ-013 ISSUE: o_scyc=o_sstb=1; present lowest-index unissued pending lane; advance on !i_sstall; after the last lane is issued go to DRAIN (or IDLE if all acks are already in).
REQ-014 o_wstall SHALL be 1 in ISSUE and DRAIN.
REQ-015 Each i_sack SHALL write i_sdata into the lowest-index unacknowledged pending lane of the return register; skipped lanes read 0.
REQ-016 Outstanding counter: increment on issue, decrement on ack, both in the same cycle means no change; width log2 R+1 bits; it never exceeds R.
REQ-017 When the final pending ack arrives (ISSUE or DRAIN), o_wack SHALL pulse 1 cycle later with the assembled o_wdata; state returns to IDLE; o_scyc drops in that same cycle.
REQ-018 i_serr while o_scyc SHALL: o_werr=1 for one cycle, next cycle; o_scyc=o_sstb=0 next cycle; remaining lanes abandoned; return to IDLE; no o_wack.
REQ-019 i_wcyc low mid-operation SHALL drop o_scyc/o_sstb next cycle, discard state, return to IDLE, and suppress o_wack/o_werr.
REQ-020 i_sack/i_serr while !o_scyc SHALL be ignored.
REQ-021 o_wack and o_werr SHALL never both be 1; at most one response per accepted request.
REQ-022 OPT_LOWPOWER: o_sdata, o_ssel, o_saddr SHALL be 0 when !o_sstb, and o_wdata SHALL be 0 when !o_wack.

Reset
REQ-023 i_reset SHALL force IDLE, clear the counter and mask, and set o_scyc, o_sstb, o_wack, o_werr to 0 on the next edge.
REQ-024 i_reset SHALL clear o_swe, o_saddr, o_sdata, o_ssel, o_wdata to 0; o_wstall SHALL read 0 after reset.
REQ-025 Reset mid-transaction SHALL produce no o_wack/o_werr for the aborted request.

Structure
REQ-026 No shared package; R and log2 R are module-local localparams.
REQ-027 Single module, no sub-modules; lane selection uses a local find-lowest-set-bit function.

Verification (WIDE_DW=128, SMALL_DW=32, little-endian)
REQ-028 Write addr 0x10, sel 0xFFFF, data 0x44..33..22..11 -> 4 small writes at 0x40..0x43 with data 0x11,0x22,0x33,0x44, then one o_wack.
REQ-029 Read sel 0x0F00 -> single small read at lane 2; i_sdata=0xDEADBEEF -> o_wdata=0x00000000_DEADBEEF_00000000_00000000.
REQ-030 sel 0x0000 -> no o_scyc; o_wack the cycle after accept, with o_wdata 0.
REQ-031 i_sstall held 3 cycles on lane 1 of a 4-lane read -> o_saddr stable; all 4 lanes still returned in order.
REQ-032 i_serr on the 2nd ack -> o_werr one pulse, o_scyc low next cycle, no o_wack; next request completes normally.
REQ-033 i_wcyc dropped (or i_reset) during DRAIN -> o_scyc low next cycle; late i_sack ignored; no response pulses.
